// File: rtl/queue_pkg.sv
// queue_pkg: shared defaults and types for the queue block
package queue_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);
    typedef logic [DEF_DATA_W-1:0] word_t;
endpackage

// File: rtl/queue_mem.sv
// queue_mem: simple dual-port storage, synchronous write, combinational read
module queue_mem
    import queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    // store the word on an accepted write; contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/queue.sv
// queue: circular-buffer FIFO with registered pop/peek read port (QUEUE_ERR_FLAGS_EN adds overflow/underflow)
module queue
    import queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write,
    input  logic                       pop,
    input  logic                       peek,
    input  logic [DATA_W-1:0]          write_value,
    output logic [DATA_W-1:0]          read_value,
    output logic                       read_valid,
    output logic                       empty,
    output logic                       full,
`ifdef QUEUE_ERR_FLAGS_EN
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic [DATA_W-1:0] rval_q, rval_d, head;
    logic              rvalid_q, rvalid_d;
    logic              do_wr, do_pop, do_rd;
    queue_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .we_i    (do_wr),
        .waddr_i (wptr_q),
        .wdata_i (write_value),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );
    // accept decisions and next-state values; a pop frees a slot for a same-cycle write at full
    always_comb begin
        do_pop   = pop && !empty_q;
        do_rd    = (pop || peek) && !empty_q;
        do_wr    = write && (!full_q || do_pop);
        wptr_d   = wptr_q + AW'(do_wr);
        rptr_d   = rptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_wr) - CW'(do_pop);
        empty_d  = count_d == '0;
        full_d   = count_d == CW'(DEPTH);
        rval_d   = do_rd ? head : rval_q;
        rvalid_d = do_rd;
    end
    // state registers, reset wins over any request in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            rval_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            rval_q   <= rval_d;
            rvalid_q <= rvalid_d;
        end
    end
`ifdef QUEUE_ERR_FLAGS_EN
    logic ovf_q, unf_q;
    // sticky error flags for dropped writes and reads on empty
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (write && full_q && !do_pop);
            unf_q <= unf_q | ((pop || peek) && empty_q);
        end
    end
    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif
    assign read_value = rval_q;
    assign read_valid = rvalid_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign count      = count_q;
endmodule

// File: tb/tb_queue.sv
// tb_queue: directed self-checking bench for queue
module tb_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0, pop = 1'b0, peek = 1'b0;
    logic [15:0] write_value = '0;
    logic [15:0] read_value;
    logic        read_valid, empty, full;
    logic [4:0]  count;
`ifdef QUEUE_ERR_FLAGS_EN
    logic        overflow, underflow;
`endif
    int total = 0, bad = 0;
    logic [15:0] model [$];
    logic [15:0] exp_v;

    queue dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .pop         (pop),
        .peek        (peek),
        .write_value (write_value),
        .read_value  (read_value),
        .read_valid  (read_valid),
        .empty       (empty),
        .full        (full),
`ifdef QUEUE_ERR_FLAGS_EN
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic p, input logic k, input logic [15:0] v);
        write = w;
        pop = p;
        peek = k;
        write_value = v;
        @(posedge clk);
        #1;
        write = 1'b0;
        pop = 1'b0;
        peek = 1'b0;
    endtask

    initial begin
        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 16'h5a5a);
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rval", read_value, 0);
        chk("rst_rvalid", read_valid, 0);
        // basic ordering
        for (int i = 1; i <= 3; i++) cyc(1, 0, 0, 16'(i));
        chk("w3_count", count, 3);
        chk("w3_empty", empty, 0);
        chk("w3_rvalid", read_valid, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("pop_val", read_value, i);
            chk("pop_valid", read_valid, 1);
        end
        chk("pop3_empty", empty, 1);
        cyc(0, 0, 0, 0);
        chk("idle_valid", read_valid, 0);
        chk("idle_hold", read_value, 3);
        // peek
        cyc(1, 0, 0, 16'h00aa);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, 0);
            chk("peek_val", read_value, 16'h00aa);
            chk("peek_valid", read_valid, 1);
            chk("peek_count", count, 1);
        end
        cyc(0, 1, 0, 0);
        chk("peekpop_val", read_value, 16'h00aa);
        chk("peekpop_empty", empty, 1);
        // reads on empty are ignored
        cyc(0, 1, 0, 0);
        chk("upop_val", read_value, 16'h00aa);
        chk("upop_valid", read_valid, 0);
        chk("upop_count", count, 0);
        cyc(0, 0, 1, 0);
        chk("upeek_valid", read_valid, 0);
`ifdef QUEUE_ERR_FLAGS_EN
        chk("underflow", underflow, 1);
        chk("no_overflow", overflow, 0);
`endif
        // fill, drop on full, drain
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 16'(i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        cyc(1, 0, 0, 16'hffff);
        chk("drop_count", count, 16);
        chk("drop_full", full, 1);
`ifdef QUEUE_ERR_FLAGS_EN
        chk("overflow", overflow, 1);
`endif
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 0);
            chk("drain_val", read_value, i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_full", full, 0);
        // write+pop at full with pointer wrap
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 16'h0100 + 16'(i));
            model.push_back(16'h0100 + 16'(i));
        end
        for (int i = 0; i < 40; i++) begin
            exp_v = model.pop_front();
            model.push_back(i == 0 ? 16'h1234 : 16'h2000 + 16'(i));
            cyc(1, 1, 0, i == 0 ? 16'h1234 : 16'h2000 + 16'(i));
            chk("wp_val", read_value, exp_v);
            chk("wp_count", count, 16);
        end
        chk("wp_full", full, 1);
        for (int i = 0; i < 16; i++) begin
            exp_v = model.pop_front();
            cyc(0, 1, 0, 0);
            chk("wrap_drain", read_value, exp_v);
        end
        chk("wrap_empty", empty, 1);
        // write+pop on empty takes the write only
        cyc(1, 1, 0, 16'h0055);
        chk("wpe_count", count, 1);
        chk("wpe_valid", read_valid, 0);
        cyc(1, 0, 0, 16'h0066);
        // pop with peek acts as pop
        cyc(0, 1, 1, 0);
        chk("pp_val", read_value, 16'h0055);
        chk("pp_count", count, 1);
        cyc(0, 1, 0, 0);
        chk("pp2_val", read_value, 16'h0066);
        // reset priority
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0700 + 16'(i));
        chk("pre_rst_count", count, 5);
        rst = 1'b1;
        cyc(1, 0, 0, 16'h0abc);
        rst = 1'b0;
        chk("rst2_count", count, 0);
        chk("rst2_empty", empty, 1);
        chk("rst2_rval", read_value, 0);
        chk("rst2_rvalid", read_valid, 0);
        cyc(0, 1, 0, 0);
        chk("rst2_pop_valid", read_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/queue.md
QUEUE -- requirements
Module: queue

Interface
REQ-001 Parameter DATA_W, default 16: width of stored words and of write_value/read_value.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 write  input  1  enqueue request; write_value is captured on the same edge.
REQ-006 pop  input  1  dequeue request; head is removed and presented.
REQ-007 peek  input  1  read head without removing it.
REQ-008 write_value  input  DATA_W  data to enqueue.
REQ-009 read_value  output  DATA_W  registered head data from the last accepted pop/peek.
REQ-010 read_valid  output  1  one-cycle pulse: read_value was updated this cycle.
REQ-011 empty  output  1  count == 0 (registered).
REQ-012 full  output  1  count == DEPTH (registered).
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Storage SHALL be a circular buffer with a write pointer, a read pointer and a count register; pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 A write SHALL be accepted when write=1 and full=0 (or when full=1 and an accepted pop occurs in the same cycle); an accepted write stores write_value at the write pointer and advances it.
REQ-016 A write while full without a simultaneous accepted pop SHALL be dropped with no state change.
REQ-017 A pop SHALL be accepted when pop=1 and empty=0; it advances the read pointer, loads the old head into read_value, and pulses read_valid on the next cycle.
REQ-018 A peek SHALL be accepted when peek=1, pop=0 and empty=0; it loads the head into read_value and pulses read_valid without changing pointers or count.
REQ-019 pop and peek together SHALL behave as pop alone.
REQ-020 pop or peek while empty SHALL be ignored: read_value holds its value and read_valid stays 0.
REQ-021 write+pop both accepted in one cycle SHALL leave count unchanged.
REQ-022 write+pop while empty SHALL accept only the write, with no bypass, leaving count=1.
REQ-023 Read latency SHALL be one cycle: read_value and read_valid are valid in the cycle after the request edge.
REQ-024 read_value SHALL hold its last value when no pop/peek is accepted.
REQ-025 count, empty and full SHALL reflect the accepted operations of the previous edge.

Reset
REQ-026 On rst=1 at a clock edge: pointers=0, count=0, empty=1, full=0, read_value=0, read_valid=0; storage contents are not cleared.
REQ-027 rst SHALL take priority over write/pop/peek in the same cycle; in-flight data is discarded.

Configuration
REQ-028 Macro QUEUE_ERR_FLAGS_EN, when defined, SHALL add outputs overflow and underflow (1 bit each).
REQ-029 overflow SHALL be set sticky by a dropped write, and underflow SHALL be set sticky by an ignored pop/peek on empty; both SHALL clear only on rst.
REQ-030 Without QUEUE_ERR_FLAGS_EN these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package queue_pkg SHALL hold DATA_W and DEPTH defaults, a pointer-width constant ($clog2(DEPTH)) and the data word typedef.
REQ-032 Storage SHALL be a sub-module queue_mem (simple dual-port, one synchronous write port, one read port) instantiated once in queue.

Verification
REQ-033 Reset, then write 0x0001, 0x0002, 0x0003 -> count=3, empty=0; three pops -> read_value 0x0001, 0x0002, 0x0003 each with a read_valid pulse; empty=1.
REQ-034 Write 0x00AA, then peek twice -> read_value=0x00AA both times, count stays 1; pop -> 0x00AA, empty=1.
REQ-035 Fill with 0x0000..0x000F -> full=1; write 0xFFFF -> dropped (overflow=1 if enabled); drain -> values 0x0000..0x000F in order.
REQ-036 Pop on empty -> read_value unchanged, read_valid=0, count=0 (underflow=1 if enabled).
REQ-037 At full, write 0x1234 and pop together -> head popped, count stays 16, 0x1234 appears last on drain; repeat for 40 cycles to exercise pointer wrap.
REQ-038 With count=5, assert rst with write=1 -> next cycle count=0, empty=1, read_value=0.
